prv32_branch_resolver: RTL and testbench
========================================

PRV32_BRANCH_RESOLVER -- requirements
Module: prv32_branch_resolver

Interface
REQ-001: The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush is held after a misprediction (legal range 1..15).
REQ-002: The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the pc_next value after reset.
REQ-003: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: rst_n  input  1  reset, synchronous, active-low.
REQ-005: valid_in  input  1  upstream presents a resolvable instruction.
REQ-006: ready_in  output  1  block can accept an instruction this cycle.
REQ-007: is_branch, is_jal, is_jalr  input  1 each  instruction class; one-hot or all zero.
REQ-008: funct3  input  3  branch condition code.
REQ-009: pc, imm  input  32 each  instruction address and sign-extended immediate.
REQ-010: alu_r  input  32  ALU result; the jump base for JALR.
REQ-011: cf, zf, vf, sf  input  1 each  ALU flags from the a-b subtraction (alufn 4'b0001).
REQ-012: pred_taken  input  1  fetch-stage prediction for this instruction.
REQ-013: valid_out  output  1  a resolved result is held.
REQ-014: ready_out  input  1  downstream consumes the result.
REQ-015: pc_next  output  32  resolved next PC.
REQ-016: taken, mispredict, illegal  output  1 each  resolution qualifiers, valid while valid_out=1.
REQ-017: flush  output  1  pipeline flush request.

Function
REQ-018: States SHALL be IDLE, HOLD and FLUSH; ready_in=1 only in IDLE, and an instruction is accepted when valid_in&ready_in.
REQ-019: On accept, the block SHALL register the result and move to HOLD, so valid_out rises exactly 1 cycle after acceptance.
REQ-020: For is_branch, condition by funct3 SHALL be: 000 zf; 001 ~zf; 100 sf^vf; 101 ~(sf^vf); 110 ~cf; 111 cf.
REQ-021: For is_branch with funct3 010 or 011, the result SHALL be taken=0 and illegal=1; illegal=0 in all other cases.
REQ-022: is_jal and is_jalr SHALL force taken=1.
REQ-023: The target SHALL be pc+imm for a branch or JAL and {alu_r[31:1],1'b0} for JALR, with 32-bit wrap-around and no carry kept; not taken SHALL give pc+4 (wrapping).
REQ-024: An accepted instruction with no class bit set SHALL resolve as taken=0 with pc_next=pc+4.
REQ-025: mispredict SHALL equal taken^pred_taken.
REQ-026: In HOLD, valid_out and all result outputs SHALL stay stable until ready_out=1.
REQ-027: On consumption in HOLD, the block SHALL go to FLUSH if mispredict=1, otherwise to IDLE.
REQ-028: In FLUSH, flush SHALL be 1 for exactly FLUSH_CYCLES cycles (down-counter), then the block returns to IDLE; flush SHALL be 0 in every other state.
REQ-029: valid_in SHALL be ignored in HOLD and FLUSH, and no instruction is lost since ready_in=0.
REQ-030: ready_out while valid_out=0 SHALL have no effect.

Reset
REQ-031: While rst_n=0 at a clock edge, the block SHALL enter IDLE with valid_out=0, taken=0, mispredict=0, illegal=0, flush=0, pc_next=RESET_PC, flush counter=0.
REQ-032: Reset SHALL take priority over all events, including mid-HOLD and mid-FLUSH, and any pending result or remaining flush cycles SHALL be discarded.

Configuration
REQ-033: With macro PRV32_BRU_PERF_EN defined, the block SHALL add two 32-bit outputs, branch_cnt and mispredict_cnt, reset to 0.
REQ-034: With PRV32_BRU_PERF_EN, each counter SHALL increment by 1 on each consumption (valid_out&ready_out) whose result qualifies: every consumption for branch_cnt, mispredict=1 for mispredict_cnt; both wrap at 2^32.
REQ-035: Without PRV32_BRU_PERF_EN, the counter ports and their logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-036: BEQ, pc=0x100, imm=0x20, zf=1, pred_taken=1 -> valid_out one cycle after accept, pc_next=0x120, taken=1, mispredict=0, no flush.
REQ-037: BLTU, cf=0, pc=0x200, imm=0xFFFFFFF0, pred_taken=0 -> pc_next=0x1F0, mispredict=1; after ready_out, flush=1 for exactly 2 cycles, ready_in=0 throughout.
REQ-038: JALR, alu_r=0x2003, pred_taken=1 -> pc_next=0x2002, taken=1; BGE with sf=1, vf=1 -> taken=1; BLT same flags -> taken=0, pc_next=pc+4.
REQ-039: Backpressure: ready_out=0 for 5 cycles -> outputs stable, valid_in pulses ignored; pc=0xFFFFFFFC not taken -> pc_next=0x0.
REQ-040: rst_n=0 in first FLUSH cycle -> next cycle flush=0, ready_in=1, pc_next=RESET_PC; funct3=010 branch -> illegal=1, taken=0.
REQ-041: With PRV32_BRU_PERF_EN, 3 branches, 1 mispredicted -> branch_cnt=3, mispredict_cnt=1.

Source files
------------

// File: rtl/prv32_branch_resolver.sv
// Branch/jump resolver: computes taken, next PC and misprediction, then holds the result and requests a flush.
// Optional macro PRV32_BRU_PERF_EN adds branch_cnt / mispredict_cnt performance counters.
module prv32_branch_resolver #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_r,
  input  logic        cf,
  input  logic        zf,
  input  logic        vf,
  input  logic        sf,
  input  logic        pred_taken,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [31:0] pc_next,
  output logic        taken,
  output logic        mispredict,
  output logic        illegal,
  output logic        flush
`ifdef PRV32_BRU_PERF_EN
  ,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
`endif
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic            accept_c;
  logic            consume_c;
  logic            cond_c;
  logic            bad_f3_c;
  logic            taken_c;
  logic            illegal_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] pc_next_c;

  assign accept_c  = valid_in & ready_in;
  assign consume_c = valid_out & ready_out;

  // Condition decode from ALU flags of a-b
  always_comb begin
    cond_c   = 1'b0;
    bad_f3_c = 1'b0;
    case (funct3)
      3'b000:  cond_c = zf;
      3'b001:  cond_c = ~zf;
      3'b100:  cond_c = sf ^ vf;
      3'b101:  cond_c = ~(sf ^ vf);
      3'b110:  cond_c = ~cf;
      3'b111:  cond_c = cf;
      default: bad_f3_c = 1'b1;
    endcase
  end

  always_comb begin
    taken_c   = is_jal | is_jalr | (is_branch & cond_c & ~bad_f3_c);
    illegal_c = is_branch & bad_f3_c;
    target_c  = is_jalr ? {alu_r[XLEN-1:1], 1'b0} : pc + imm;
    pc_next_c = taken_c ? target_c : pc + XLEN'(4);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ready_out) begin
          if (mispredict) begin
            state_d = S_FLUSH;
            fcnt_d  = CW'(FLUSH_CYCLES);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        fcnt_d = fcnt_q - CW'(1);
        if (fcnt_q <= CW'(1)) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fcnt_q    <= '0;
      ready_in  <= 1'b1;
      valid_out <= 1'b0;
      flush     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      ready_in  <= (state_d == S_IDLE);
      valid_out <= (state_d == S_HOLD);
      flush     <= (state_d == S_FLUSH);
    end
  end

  // Result registers only load on accept, so they stay frozen through HOLD
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_next    <= RESET_PC;
      taken      <= 1'b0;
      mispredict <= 1'b0;
      illegal    <= 1'b0;
    end else if (accept_c) begin
      pc_next    <= pc_next_c;
      taken      <= taken_c;
      mispredict <= taken_c ^ pred_taken;
      illegal    <= illegal_c;
    end
  end

`ifdef PRV32_BRU_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (consume_c) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end
`else
  logic unused_c;
  assign unused_c = consume_c;
`endif

endmodule

// File: tb/tb_prv32_branch_resolver.sv
// Scoreboard bench for prv32_branch_resolver: driver pushes expected results, monitor pops on output.
module tb_prv32_branch_resolver;

  localparam logic [31:0] RPC = 32'h0000_0080;
  localparam int          FC  = 2;

  typedef struct {
    logic [31:0] pc_next;
    logic        taken;
    logic        mis;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, ready_in;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [31:0] pc, imm, alu_r;
  logic        cf, zf, vf, sf, pred_taken;
  logic        valid_out, ready_out;
  logic [31:0] pc_next;
  logic        taken, mispredict, illegal, flush;
`ifdef PRV32_BRU_PERF_EN
  logic [31:0] branch_cnt, mispredict_cnt;
`endif

  prv32_branch_resolver #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .pc(pc), .imm(imm), .alu_r(alu_r), .cf(cf), .zf(zf), .vf(vf), .sf(sf),
    .pred_taken(pred_taken), .valid_out(valid_out), .ready_out(ready_out),
    .pc_next(pc_next), .taken(taken), .mispredict(mispredict), .illegal(illegal),
    .flush(flush)
`ifdef PRV32_BRU_PERF_EN
    , .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   fexp = 0;
  int   rmode = 0;
  int   n_cons = 0;
  int   n_mis = 0;
  bit   mon_en = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: branch outcome from the compared operands themselves
  function automatic exp_t model(input int cls, input logic [2:0] f3, input logic [31:0] ipc,
                                 input logic [31:0] iimm, input logic [31:0] alu,
                                 input logic [31:0] a, input logic [31:0] b, input logic pred);
    exp_t e;
    logic t;
    t     = 1'b0;
    e.ill = 1'b0;
    if (cls == 1) begin
      case (f3)
        3'd0:    t = (a == b);
        3'd1:    t = (a != b);
        3'd4:    t = ($signed(a) < $signed(b));
        3'd5:    t = ($signed(a) >= $signed(b));
        3'd6:    t = (a < b);
        3'd7:    t = (a >= b);
        default: e.ill = 1'b1;
      endcase
    end else if (cls >= 2) begin
      t = 1'b1;
    end
    e.taken = t;
    e.mis   = t ^ pred;
    if (!t)            e.pc_next = ipc + 32'd4;
    else if (cls == 3) e.pc_next = alu & 32'hFFFF_FFFE;
    else               e.pc_next = ipc + iimm;
    return e;
  endfunction

  task automatic drive(input int cls, input logic [2:0] f3, input logic [31:0] ipc,
                       input logic [31:0] iimm, input logic [31:0] alu,
                       input logic [31:0] a, input logic [31:0] b, input logic pred);
    logic [32:0] s;
    s          = {1'b0, a} + {1'b0, ~b} + 33'd1;
    is_branch  = (cls == 1);
    is_jal     = (cls == 2);
    is_jalr    = (cls == 3);
    funct3     = f3;
    pc         = ipc;
    imm        = iimm;
    alu_r      = alu;
    cf         = s[32];
    zf         = (s[31:0] == 32'd0);
    sf         = s[31];
    vf         = (a[31] != b[31]) && (s[31] != a[31]);
    pred_taken = pred;
  endtask

  task automatic send(input int cls, input logic [2:0] f3, input logic [31:0] ipc,
                      input logic [31:0] iimm, input logic [31:0] alu,
                      input logic [31:0] a, input logic [31:0] b, input logic pred);
    int n;
    @(posedge clk); #1;
    drive(cls, f3, ipc, iimm, alu, a, b, pred);
    valid_in = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!ready_in) begin
      chk1("accept_timeout", ready_in, 1'b1);
      valid_in = 1'b0;
    end else begin
      @(posedge clk);
      q.push_back(model(cls, f3, ipc, iimm, alu, a, b, pred));
      #1 valid_in = 1'b0;
      drive($urandom_range(0, 3), 3'($urandom), $urandom, $urandom, $urandom,
            $urandom, $urandom, 1'($urandom));
    end
  endtask

  // Downstream readiness
  initial begin
    ready_out = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       ready_out = ($urandom_range(0, 2) != 0);
        1:       ready_out = 1'b0;
        default: ready_out = 1'b1;
      endcase
    end
  end

  // Monitor: checks handshake, flush window and held result against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk1("valid_out", valid_out, q.size() != 0);
        chk1("ready_in", ready_in, (q.size() == 0) && (fexp == 0));
        chk1("flush", flush, fexp != 0);
        if (fexp != 0) fexp--;
        if (valid_out && q.size() != 0) begin
          e = q[0];
          chk32("pc_next", pc_next, e.pc_next);
          chk1("taken", taken, e.taken);
          chk1("mispredict", mispredict, e.mis);
          chk1("illegal", illegal, e.ill);
          if (ready_out) begin
            void'(q.pop_front());
            n_cons++;
            if (e.mis) begin
              n_mis++;
              fexp = FC;
            end
          end
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk1({tag, "_valid_out"}, valid_out, 1'b0);
    chk1({tag, "_ready_in"}, ready_in, 1'b1);
    chk1({tag, "_flush"}, flush, 1'b0);
    chk1({tag, "_taken"}, taken, 1'b0);
    chk1({tag, "_mispredict"}, mispredict, 1'b0);
    chk1({tag, "_illegal"}, illegal, 1'b0);
    chk32({tag, "_pc_next"}, pc_next, RPC);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || fexp != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("drain_timeout", (q.size() == 0 && fexp == 0), 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    drive(0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed cases
    send(1, 3'd0, 32'h100, 32'h20, 32'h0, 32'd5, 32'd5, 1'b1);
    send(1, 3'd6, 32'h200, 32'hFFFF_FFF0, 32'h0, 32'd1, 32'd2, 1'b0);
    send(3, 3'd0, 32'h300, 32'h0, 32'h2003, 32'd0, 32'd0, 1'b1);
    send(1, 3'd5, 32'h400, 32'h80, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(1, 3'd4, 32'h400, 32'h80, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send(2, 3'd3, 32'h10, 32'h40, 32'h0, 32'd0, 32'd0, 1'b0);
    send(0, 3'd0, 32'h500, 32'h40, 32'h0, 32'd3, 32'd3, 1'b1);
    wait_idle();

    // Backpressure with ignored valid_in pulses and PC wrap
    rmode = 1;
    send(1, 3'd1, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'd9, 32'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 3), 3'($urandom), $urandom, $urandom, $urandom,
            $urandom, $urandom, 1'($urandom));
      valid_in = (i % 2 == 0);
    end
    @(posedge clk); #1 valid_in = 1'b0;
    rmode = 0;
    wait_idle();

    // Reset in the first flush cycle
    rmode = 2;
    send(1, 3'd7, 32'h600, 32'h100, 32'h0, 32'd1, 32'd2, 1'b1);
    n = 0;
    @(negedge clk);
    while (!flush && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk1("flush_seen", flush, 1'b1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("midflush");
    q.delete();
    fexp   = 0;
    n_cons = 0;
    n_mis  = 0;
    mon_en = 1'b1;
    rmode  = 0;

    // Reserved funct3 branch
    send(1, 3'd2, 32'h700, 32'h40, 32'h0, 32'd4, 32'd4, 1'b1);
    send(1, 3'd3, 32'h700, 32'h40, 32'h0, 32'd4, 32'd5, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a + 32'd1;
        2:       b = {~a[31], a[30:0]};
        default: b = $urandom;
      endcase
      send($urandom_range(0, 3), 3'($urandom), $urandom, $urandom, $urandom,
           a, b, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();

`ifdef PRV32_BRU_PERF_EN
    @(negedge clk);
    chk32("branch_cnt", branch_cnt, 32'(n_cons));
    chk32("mispredict_cnt", mispredict_cnt, 32'(n_mis));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
